// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: raster timing outputs shared between the sync generator and the pixel generator
interface vga_sync_gen_if;
  logic p_tick;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic video_on;
  logic hsync;
  logic vsync;
  logic frame_tick;
  modport master(output p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_tick);
  modport slave(input p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_tick);
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel-rate divider plus horizontal/vertical raster counters with registered sync, blanking and frame strobe
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input logic clk_d,
  input logic reset,
  vga_sync_gen_if.master vga
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam logic [3:0] D_MAX = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS = 10'(V_DISPLAY);
  localparam logic [9:0] V_LAST_VIS = 10'(V_DISPLAY - 1);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  logic [3:0] div;
  logic [9:0] x, y, x_nxt, y_nxt;
  logic p_tick, h_wrap, hs, vs, von, ft;
  assign p_tick = div == D_MAX;
  assign h_wrap = p_tick && x == H_MAX;
  // Wraps are explicit compares so the adders never roll over
  always_comb begin
    x_nxt = p_tick ? (h_wrap ? '0 : x + 10'd1) : x;
    y_nxt = h_wrap ? (y == V_MAX ? '0 : y + 10'd1) : y;
  end
  always_ff @(posedge clk_d) begin
    if (reset) begin
      div <= '0;
      x   <= '0;
      y   <= '0;
      hs  <= 1'b1;
      vs  <= 1'b1;
      von <= 1'b1;
      ft  <= 1'b0;
    end else begin
      div <= p_tick ? '0 : div + 4'd1;
      x   <= x_nxt;
      y   <= y_nxt;
      hs  <= !(x_nxt >= HS_START && x_nxt <= HS_END);
      vs  <= !(y_nxt >= VS_START && y_nxt <= VS_END);
      von <= x_nxt < H_VIS && y_nxt < V_VIS;
      ft  <= h_wrap && y == V_LAST_VIS;
    end
  end
  assign vga.p_tick     = p_tick;
  assign vga.pixel_x    = x;
  assign vga.pixel_y    = y;
  assign vga.video_on   = von;
  assign vga.hsync      = hs;
  assign vga.vsync      = vs;
  assign vga.frame_tick = ft;
endmodule
